dcache_tag_nway: RTL and testbench

Set-associative tag/state array for the data cache, the parametrised successor of the direct-mapped tag store. Per set and way it holds tag, valid and dirty bits plus a per-set round-robin replacement pointer. It answers hit/way and victim queries combinationally and runs a multi-cycle invalidate-all walk. It sits between the LSU-side cache controller (lookups, dirty marking) and the refill/writeback FSM (victim selection, fills).

---
 rtl/dcache_tag_nway_pkg.sv | 27 ++
 rtl/dcache_tag_way.sv | 65 ++++++
 rtl/dcache_tag_nway.sv | 200 ++++++++++++++++++++
 tb/tb_dcache_tag_nway.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_tag_nway_pkg.sv
// Shared defaults, flush FSM states and width helpers
// for the set-associative data cache tag array.
package dcache_tag_nway_pkg;

  localparam int DCACHE_TAG_LEN = 23;
  localparam int DCACHE_IDX_LEN = 5;
  localparam int DCACHE_WAY_NUM = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WALK = 1'b1
  } flush_st_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int way_bits(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/dcache_tag_way.sv
// One way of the tag array: per-set tag/valid/dirty storage,
// tag compare at i_index, and clear/fill/mark write ports.
// Ports:
//   clk, rst                    clock, async active-high reset
//   i_index, i_tag              request set and tag
//   i_fill_we, i_fill_dirty     fill this way at i_index
//   i_mark_we                   set dirty at i_index
//   i_clr_we, i_clr_idx         invalidate one set (flush walk)
//   o_match                     valid & tag equal at i_index
//   o_valid, o_dirty, o_tag     stored line state at i_index
module dcache_tag_way
  import dcache_tag_nway_pkg::*;
#(
  parameter int TAG_LEN = DCACHE_TAG_LEN,
  parameter int IDX_LEN = DCACHE_IDX_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_LEN-1:0] i_index,
  input  logic [TAG_LEN-1:0] i_tag,
  input  logic               i_fill_we,
  input  logic               i_fill_dirty,
  input  logic               i_mark_we,
  input  logic               i_clr_we,
  input  logic [IDX_LEN-1:0] i_clr_idx,
  output logic               o_match,
  output logic               o_valid,
  output logic               o_dirty,
  output logic [TAG_LEN-1:0] o_tag
);

  localparam int SET_NUM = 1 << IDX_LEN;

  logic [TAG_LEN-1:0] r_tag [SET_NUM];
  logic [SET_NUM-1:0] r_valid;
  logic [SET_NUM-1:0] r_dirty;

  // Clear outranks fill outranks mark; the top never
  // raises more than one, this just keeps it explicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SET_NUM; s++) begin
        r_tag[s] <= '0;
      end
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_clr_we) begin
      r_valid[i_clr_idx] <= 1'b0;
      r_dirty[i_clr_idx] <= 1'b0;
    end else if (i_fill_we) begin
      r_tag[i_index]   <= i_tag;
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= i_fill_dirty;
    end else if (i_mark_we) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_match = r_valid[i_index] &
                   (r_tag[i_index] == i_tag);

endmodule

// File: rtl/dcache_tag_nway.sv
// N-way set-associative D-cache tag/state array with
// round-robin replacement and an invalidate-all walk.
// Ports:
//   clk, rst                 clock, async active-high reset
//   tag_i, index_i           request tag and set
//   lookup_valid_i           qualifies hit_o
//   mark_dirty_i             set dirty on the hit way
//   fill_valid_i/dirty_i     write tag_i into victim way
//   flush_i                  start invalidate-all walk
//   hit_o, hit_way_o         lookup result (lowest way)
//   victim_*_o               way a fill would use + its state
//   busy_o, flush_done_o     walk in progress / finished pulse
module dcache_tag_nway
  import dcache_tag_nway_pkg::*;
#(
  parameter int TAG_LEN = DCACHE_TAG_LEN,
  parameter int IDX_LEN = DCACHE_IDX_LEN,
  parameter int WAY_NUM = DCACHE_WAY_NUM,
  localparam int WAY_W = way_bits(WAY_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TAG_LEN-1:0] tag_i,
  input  logic [IDX_LEN-1:0] index_i,
  input  logic               lookup_valid_i,
  input  logic               mark_dirty_i,
  input  logic               fill_valid_i,
  input  logic               fill_dirty_i,
  input  logic               flush_i,
  output logic               hit_o,
  output logic [WAY_W-1:0]   hit_way_o,
  output logic [WAY_W-1:0]   victim_way_o,
  output logic               victim_valid_o,
  output logic               victim_dirty_o,
  output logic [TAG_LEN-1:0] victim_tag_o,
  output logic               busy_o,
  output logic               flush_done_o
);

  localparam int SET_NUM = 1 << IDX_LEN;

  flush_st_e          r_state;
  flush_st_e          w_state_nxt;
  logic [IDX_LEN-1:0] r_cnt;
  logic [IDX_LEN-1:0] w_cnt_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_clr;

  logic [WAY_W-1:0]   r_ptr [SET_NUM];
  logic [WAY_W-1:0]   w_ptr_nxt;

  logic [WAY_NUM-1:0] w_match;
  logic [WAY_NUM-1:0] w_valid;
  logic [WAY_NUM-1:0] w_dirty;
  logic [WAY_NUM-1:0] w_fill_we;
  logic [WAY_NUM-1:0] w_mark_we;
  logic [TAG_LEN-1:0] w_tag [WAY_NUM];

  logic               w_busy;
  logic               w_full;
  logic               w_fill_en;
  logic               w_mark_en;
  logic [WAY_W-1:0]   w_hit_way;
  logic [WAY_W-1:0]   w_vic_way;

  for (genvar g = 0; g < WAY_NUM; g++) begin : g_way
    dcache_tag_way #(
      .TAG_LEN (TAG_LEN),
      .IDX_LEN (IDX_LEN)
    ) u_way (
      .clk          (clk),
      .rst          (rst),
      .i_index      (index_i),
      .i_tag        (tag_i),
      .i_fill_we    (w_fill_we[g]),
      .i_fill_dirty (fill_dirty_i),
      .i_mark_we    (w_mark_we[g]),
      .i_clr_we     (w_clr),
      .i_clr_idx    (r_cnt),
      .o_match      (w_match[g]),
      .o_valid      (w_valid[g]),
      .o_dirty      (w_dirty[g]),
      .o_tag        (w_tag[g])
    );
  end

  assign w_busy    = (r_state == S_WALK);
  assign w_full    = &w_valid;
  assign w_fill_en = fill_valid_i & ~w_busy;
  assign hit_o     = lookup_valid_i & ~w_busy & (|w_match);
  // A simultaneous fill owns the write port; the mark is lost.
  assign w_mark_en = mark_dirty_i & hit_o & ~fill_valid_i;

  assign hit_way_o    = w_hit_way;
  assign victim_way_o = w_vic_way;
  assign busy_o       = w_busy;
  assign flush_done_o = r_done;

  always_comb begin
    w_hit_way = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_way = WAY_W'(i);
    end
  end

  // Free ways are used first; RR only decides on a full set.
  always_comb begin
    w_vic_way = r_ptr[index_i];
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (!w_valid[i]) w_vic_way = WAY_W'(i);
    end
  end

  always_comb begin
    victim_valid_o = 1'b0;
    victim_dirty_o = 1'b0;
    victim_tag_o   = '0;
    w_fill_we      = '0;
    w_mark_we      = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      if (w_vic_way == WAY_W'(i)) begin
        victim_valid_o = w_valid[i];
        victim_dirty_o = w_dirty[i];
        victim_tag_o   = w_tag[i];
        w_fill_we[i]   = w_fill_en;
      end
      if (w_hit_way == WAY_W'(i)) begin
        w_mark_we[i] = w_mark_en;
      end
    end
  end

  always_comb begin
    if (WAY_NUM == 1) begin
      w_ptr_nxt = '0;
    end else if (r_ptr[index_i] == WAY_W'(WAY_NUM - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = r_ptr[index_i] + WAY_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SET_NUM; s++) begin
        r_ptr[s] <= '0;
      end
    end else if (w_clr) begin
      r_ptr[r_cnt] <= '0;
    end else if (w_fill_en && w_full) begin
      r_ptr[index_i] <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_clr       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (flush_i) begin
          w_state_nxt = S_WALK;
          w_cnt_nxt   = '0;
        end
      end
      S_WALK: begin
        w_clr     = 1'b1;
        w_cnt_nxt = r_cnt + IDX_LEN'(1);
        if (&r_cnt) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
    endcase
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && lookup_valid_i && !w_busy) begin
      assert ($countones(w_match) <= 1)
      else $error("dcache_tag_nway: multi-way tag hit");
    end
  end
`endif

endmodule

// File: tb/tb_dcache_tag_nway.sv
// Randomized self-checking bench for dcache_tag_nway
// against a per-set line-list reference model.
module tb_dcache_tag_nway;

  localparam int TL = 23;
  localparam int IL = 5;
  localparam int WN = 2;
  localparam int SN = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [TL-1:0] tag_i;
  logic [IL-1:0] index_i;
  logic          lookup_valid_i;
  logic          mark_dirty_i;
  logic          fill_valid_i;
  logic          fill_dirty_i;
  logic          flush_i;
  logic          hit_o;
  logic          hit_way_o;
  logic          victim_way_o;
  logic          victim_valid_o;
  logic          victim_dirty_o;
  logic [TL-1:0] victim_tag_o;
  logic          busy_o;
  logic          flush_done_o;

  always #5 clk = ~clk;

  dcache_tag_nway #(
    .TAG_LEN (TL),
    .IDX_LEN (IL),
    .WAY_NUM (WN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tag_i          (tag_i),
    .index_i        (index_i),
    .lookup_valid_i (lookup_valid_i),
    .mark_dirty_i   (mark_dirty_i),
    .fill_valid_i   (fill_valid_i),
    .fill_dirty_i   (fill_dirty_i),
    .flush_i        (flush_i),
    .hit_o          (hit_o),
    .hit_way_o      (hit_way_o),
    .victim_way_o   (victim_way_o),
    .victim_valid_o (victim_valid_o),
    .victim_dirty_o (victim_dirty_o),
    .victim_tag_o   (victim_tag_o),
    .busy_o         (busy_o),
    .flush_done_o   (flush_done_o)
  );

  int n_chk = 0;
  int n_err = 0;

  bit            m_v   [SN][WN];
  bit            m_d   [SN][WN];
  logic [TL-1:0] m_t   [SN][WN];
  int            m_ptr [SN];
  bit            m_busy;
  bit            m_done;
  int            m_pos;

  logic [TL-1:0] pool [6] = '{23'h1A, 23'h2B, 23'h3C,
                             23'h4D, 23'h5E, 23'h7FFFFF};

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SN; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WN; w++) begin
        m_v[s][w] = 0;
        m_d[s][w] = 0;
        m_t[s][w] = '0;
      end
    end
    m_busy = 0;
    m_done = 0;
    m_pos  = 0;
  endtask

  function automatic int m_hitway(input int idx,
                                  input logic [TL-1:0] tg);
    for (int w = 0; w < WN; w++) begin
      if (m_v[idx][w] && m_t[idx][w] == tg) return w;
    end
    return -1;
  endfunction

  function automatic int m_victim(input int idx);
    for (int w = 0; w < WN; w++) begin
      if (!m_v[idx][w]) return w;
    end
    return m_ptr[idx];
  endfunction

  task automatic check_model();
    int idx;
    int hw;
    int vw;
    bit eh;
    idx = int'(index_i);
    hw  = m_hitway(idx, tag_i);
    vw  = m_victim(idx);
    eh  = lookup_valid_i && !m_busy && (hw >= 0);
    chk("hit", hit_o, eh);
    if (eh) chk("hit_way", hit_way_o, hw);
    chk("vic_way", victim_way_o, vw);
    chk("vic_valid", victim_valid_o, m_v[idx][vw]);
    chk("vic_dirty", victim_dirty_o, m_d[idx][vw]);
    chk("vic_tag", victim_tag_o, m_t[idx][vw]);
    chk("busy", busy_o, m_busy);
    chk("done", flush_done_o, m_done);
  endtask

  task automatic model_step();
    int idx;
    int hw;
    int vw;
    bit full;
    bit dn;
    idx = int'(index_i);
    dn  = 0;
    if (m_busy) begin
      for (int w = 0; w < WN; w++) begin
        m_v[m_pos][w] = 0;
        m_d[m_pos][w] = 0;
      end
      m_ptr[m_pos] = 0;
      if (m_pos == SN - 1) begin
        m_busy = 0;
        dn     = 1;
      end else begin
        m_pos++;
      end
    end else begin
      hw   = m_hitway(idx, tag_i);
      vw   = m_victim(idx);
      full = 1;
      for (int w = 0; w < WN; w++) full &= m_v[idx][w];
      if (fill_valid_i) begin
        m_t[idx][vw] = tag_i;
        m_v[idx][vw] = 1;
        m_d[idx][vw] = fill_dirty_i;
        if (full) m_ptr[idx] = (m_ptr[idx] + 1) % WN;
      end else if (mark_dirty_i && lookup_valid_i && hw >= 0) begin
        m_d[idx][hw] = 1;
      end
      if (flush_i) begin
        m_busy = 1;
        m_pos  = 0;
      end
    end
    m_done = dn;
  endtask

  task automatic put(input bit lk, input bit fl, input bit fd,
                     input bit mk, input bit fs, input int idx,
                     input logic [TL-1:0] tg);
    @(negedge clk);
    lookup_valid_i = lk;
    fill_valid_i   = fl;
    fill_dirty_i   = fd;
    mark_dirty_i   = mk;
    flush_i        = fs;
    index_i        = IL'(idx);
    tag_i          = tg;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  int n_busy;
  int n_done;
  int r_idx;
  logic [TL-1:0] r_tag;
  bit r_fl;

  initial begin
    rst = 1'b1;
    lookup_valid_i = 0; fill_valid_i = 0; fill_dirty_i = 0;
    mark_dirty_i = 0; flush_i = 0; index_i = '0; tag_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    put(1, 0, 0, 0, 0, 3, 23'h1A);
    chk("rst_hit", hit_o, 0);
    chk("rst_vway", victim_way_o, 0);
    chk("rst_vvalid", victim_valid_o, 0);
    tick();

    put(0, 1, 0, 0, 0, 3, 23'h1A); tick();
    put(0, 1, 0, 0, 0, 3, 23'h2B); tick();
    put(1, 0, 0, 0, 0, 3, 23'h2B);
    chk("hit_2b", hit_o, 1);
    chk("way_2b", hit_way_o, 1);
    tick();
    put(1, 0, 0, 0, 0, 3, 23'h1A);
    chk("way_1a", hit_way_o, 0);
    tick();

    put(0, 1, 0, 0, 0, 3, 23'h3C);
    chk("vtag_1a", victim_tag_o, 23'h1A);
    chk("vway_3c", victim_way_o, 0);
    tick();
    put(1, 0, 0, 0, 0, 3, 23'h3C);
    chk("way_3c", hit_way_o, 0);
    chk("rr_ptr1", victim_way_o, 1);
    tick();
    put(0, 1, 0, 0, 0, 3, 23'h4D); tick();
    put(1, 0, 0, 0, 0, 3, 23'h4D);
    chk("way_4d", hit_way_o, 1);
    tick();

    put(1, 1, 0, 1, 0, 3, 23'h3C); tick();
    put(0, 1, 0, 0, 0, 3, 23'h5E); tick();
    put(0, 0, 0, 0, 0, 3, 23'h0);
    chk("mark_drop", victim_dirty_o, 0);
    tick();
    put(1, 0, 0, 1, 0, 3, 23'h3C); tick();
    put(0, 0, 0, 0, 0, 3, 23'h0);
    chk("mark_vway", victim_way_o, 0);
    chk("mark_dirty", victim_dirty_o, 1);
    tick();

    put(0, 0, 0, 0, 1, 3, 23'h0); tick();
    n_busy = 0;
    n_done = 0;
    for (int i = 0; i < 33; i++) begin
      put(1, i < 32, 1, 0, 0, 3, 23'h66);
      n_busy += int'(busy_o);
      n_done += int'(flush_done_o);
      tick();
    end
    chk("walk_len", n_busy, 32);
    chk("done_cnt", n_done, 1);
    put(1, 0, 0, 0, 0, 3, 23'h3C);
    chk("flush_3c", hit_o, 0);
    tick();
    put(1, 0, 0, 0, 0, 3, 23'h66);
    chk("flush_66", hit_o, 0);
    tick();

    put(0, 1, 0, 0, 0, 9, 23'h2B); tick();
    put(0, 0, 0, 0, 1, 0, 23'h0); tick();
    for (int i = 0; i < 10; i++) begin
      put(0, 0, 0, 0, 0, 0, 23'h0); tick();
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_done", flush_done_o, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(1, 0, 0, 0, 0, 9, 23'h2B); tick();
    end

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) r_idx = $urandom_range(0, SN - 1);
      else r_idx = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) r_tag = TL'($urandom);
      else r_tag = pool[$urandom_range(0, 5)];
      r_fl = ($urandom_range(0, 2) == 0);
      if (m_hitway(r_idx, r_tag) >= 0 && !m_busy) r_fl = 0;
      put($urandom_range(0, 1) == 1, r_fl,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 199) == 0, r_idx, r_tag);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
